mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 17, giving the RAM byte-address width.
REQ-002 The block SHALL have ports (name direction width meaning):
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req_i  in  1  instruction-fetch request, held until if_done_o.
- if_addr_i  in  32  fetch byte address.
- mem_req_i  in  1  load/store request, held until mem_done_o.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_width_i  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_addr_i  in  32  load/store byte address.
- mem_wdata_i  in  32  store data; the low bytes are used first.
- ram_din_i  in  8  RAM read byte, valid one cycle after its address.
- ram_addr_o  out  ADDR_WIDTH  RAM byte address.
- ram_dout_o  out  8  RAM write byte.
- ram_wr_o  out  1  RAM write strobe.
- if_inst_o  out  32  assembled instruction.
- if_done_o  out  1  one-cycle fetch-complete pulse.
- mem_data_o  out  32  load data, zero-extended.
- mem_done_o  out  1  one-cycle load/store-complete pulse.
- busy_o  out  1  transfer in progress.

Function
REQ-003 The block SHALL implement the FSM states IDLE, READ, WRITE and DONE.
REQ-004 The block SHALL sample requests only in IDLE; in IDLE, mem_req_i SHALL win over if_req_i when both are high.
REQ-005 On acceptance the block SHALL latch the base address, width, write data and requester.
- Fetches SHALL always be 4 bytes.
- The byte count N SHALL be 1, 2 or 4 per mem_width_i.
- A load or fetch SHALL go to READ; a store SHALL go to WRITE.
REQ-006 RAM addresses SHALL be (base + k) truncated to ADDR_WIDTH bits, wrapping at the top.
REQ-007 Each transfer SHALL be little-endian: byte k maps to data bits [8k+7:8k].
REQ-008 READ cycle k (k = 0..N): for k < N, ram_addr_o = base + k; for k >= 1, ram_din_i is captured as byte k-1 at the end of the cycle.
REQ-009 After READ cycle N the block SHALL enter DONE.
REQ-010 A read SHALL zero the unread upper bytes of the destination register.
REQ-011 WRITE cycle k (k = 0..N-1): ram_wr_o = 1, ram_addr_o = base + k, ram_dout_o = wdata byte k; after cycle N-1 the block SHALL enter DONE.
REQ-012 In DONE the block SHALL:
- assert if_done_o or mem_done_o (requester only) for exactly one cycle;
- ignore all requests;
- return to IDLE at the next edge.
REQ-013 Read latency SHALL be N+2 cycles: done is high N+2 cycles after the cycle in which the request was sampled. Store latency SHALL be N+1 cycles.
REQ-014 busy_o SHALL be 1 in READ and WRITE and 0 in IDLE and DONE.
REQ-015 if_inst_o and mem_data_o SHALL hold their last completed value until their next completion.
REQ-016 ram_wr_o SHALL be 0 outside WRITE; ram_addr_o and ram_dout_o SHALL be 0 in IDLE and DONE.
REQ-017 A request that arrives while a transfer is in progress SHALL wait, unchanged, until the next IDLE cycle.
REQ-018 A fetch that is blocked by a continuous stream of mem requests SHALL be served at the first IDLE cycle with mem_req_i low.
REQ-019 Request inputs that change mid-transfer SHALL have no effect, because all parameters are latched.

Reset
REQ-020 While rst = 0, the FSM SHALL be forced to IDLE immediately and asynchronously, and all outputs and internal registers SHALL be 0.
REQ-021 Reset asserted mid-transfer SHALL abort the transfer and drop ram_wr_o within the same cycle; no done pulse SHALL follow.
REQ-022 After rst deasserts, the first request SHALL be sampled at the first rising edge.

Verification
REQ-023 Fetch: RAM[0x100..0x103] = 13 05 A0 00; if_req_i = 1 with addr 0x100 -> ram_addr_o sequence 0x100..0x103, if_done_o 6 cycles later, if_inst_o = 0x00A00513.
REQ-024 Byte store then word load: store width 00, addr 0x20, wdata 0x123456AB -> one ram_wr_o cycle writing 0xAB at 0x20, mem_done_o 2 cycles after the request; then a word load at 0x20 -> mem_data_o low byte 0xAB.
REQ-025 Simultaneous requests: if_req_i and mem_req_i (half load, addr 0x40) both high in IDLE -> the load is served first (mem_done_o after 4 cycles), then the fetch completes 6 cycles after it is sampled; if_done_o and mem_done_o are never high together.
REQ-026 Wrap: word load at addr 0x1FFFE with ADDR_WIDTH = 17 -> ram_addr_o sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
REQ-027 Reset mid-store: rst = 0 during WRITE cycle 2 of a word store -> ram_wr_o = 0 and busy_o = 0 immediately, no mem_done_o pulse, only bytes 0-1 written.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller shared by instruction fetch and load/store.
// Transfers 1, 2 or 4 little-endian bytes through an 8-bit synchronous RAM.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [31:0]           if_addr_i,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_width_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  input  logic [7:0]            ram_din_i,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [7:0]            ram_dout_o,
  output logic                  ram_wr_o,
  output logic [31:0]           if_inst_o,
  output logic                  if_done_o,
  output logic [31:0]           mem_data_o,
  output logic                  mem_done_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [2:0]            r_cnt;
  logic [2:0]            r_n;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic [31:0]           r_inst;
  logic [31:0]           r_data;
  logic                  r_is_if;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [2:0]            w_cm1;
  logic [31:0]           w_rnext;
  logic                  w_last;
  logic                  w_unused;

  assign w_addr = r_base + ADDR_WIDTH'(r_cnt);
  assign w_cm1  = r_cnt - 3'd1;
  assign w_last = (r_cnt == r_n);

  // RAM data lags its address by one cycle, so cycle k fills byte k-1
  always_comb begin
    w_rnext = r_rdata;
    w_rnext[8*w_cm1[1:0] +: 8] = ram_din_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_cnt   <= '0;
      r_n     <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_inst  <= '0;
      r_data  <= '0;
      r_is_if <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_cnt   <= '0;
          r_rdata <= '0;
          if (mem_req_i) begin
            r_is_if <= 1'b0;
            r_base  <= mem_addr_i[ADDR_WIDTH-1:0];
            r_wdata <= mem_wdata_i;
            r_n     <= mem_width_i[1] ? 3'd4 :
                       mem_width_i[0] ? 3'd2 : 3'd1;
            r_state <= mem_we_i ? S_WRITE : S_READ;
          end else if (if_req_i) begin
            r_is_if <= 1'b1;
            r_base  <= if_addr_i[ADDR_WIDTH-1:0];
            r_n     <= 3'd4;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (r_cnt != 3'd0) r_rdata <= w_rnext;
          if (w_last) begin
            r_state <= S_DONE;
            if (r_is_if) r_inst <= w_rnext;
            else         r_data <= w_rnext;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_WRITE: begin
          if (r_cnt == r_n - 3'd1) r_state <= S_DONE;
          else                     r_cnt   <= r_cnt + 3'd1;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = (r_state == S_READ) || (r_state == S_WRITE);
  assign ram_wr_o   = (r_state == S_WRITE);
  assign ram_addr_o = (ram_wr_o || (r_state == S_READ && !w_last)) ?
                      w_addr : '0;
  assign ram_dout_o = ram_wr_o ? r_wdata[8*r_cnt[1:0] +: 8] : 8'h00;
  assign if_done_o  = (r_state == S_DONE) && r_is_if;
  assign mem_done_o = (r_state == S_DONE) && !r_is_if;
  assign if_inst_o  = r_inst;
  assign mem_data_o = r_data;

  assign w_unused = ^{if_addr_i[31:ADDR_WIDTH],
                      mem_addr_i[31:ADDR_WIDTH], w_cm1[2]};

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: RAM model, byte-level reference memory,
// per-cycle RAM access expectations and completion checking.
module tb_mem_ctrl;
  localparam int AW  = 17;
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req_i = 1'b0;
  logic [31:0]   if_addr_i = '0;
  logic          mem_req_i = 1'b0;
  logic          mem_we_i = 1'b0;
  logic [1:0]    mem_width_i = '0;
  logic [31:0]   mem_addr_i = '0;
  logic [31:0]   mem_wdata_i = '0;
  logic [7:0]    ram_din_i;
  logic [AW-1:0] ram_addr_o;
  logic [7:0]    ram_dout_o;
  logic          ram_wr_o;
  logic [31:0]   if_inst_o;
  logic          if_done_o;
  logic [31:0]   mem_data_o;
  logic          mem_done_o;
  logic          busy_o;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .mem_req_i  (mem_req_i),
    .mem_we_i   (mem_we_i),
    .mem_width_i(mem_width_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .ram_din_i  (ram_din_i),
    .ram_addr_o (ram_addr_o),
    .ram_dout_o (ram_dout_o),
    .ram_wr_o   (ram_wr_o),
    .if_inst_o  (if_inst_o),
    .if_done_o  (if_done_o),
    .mem_data_o (mem_data_o),
    .mem_done_o (mem_done_o),
    .busy_o     (busy_o)
  );

  logic [7:0] ram  [MSZ];
  logic [7:0] refm [MSZ];
  int cyc;
  int n_pass;
  int n_total;

  always @(posedge clk) begin
    if (ram_wr_o) ram[ram_addr_o] <= ram_dout_o;
    ram_din_i <= ram[ram_addr_o];
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_if;
    bit          we;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t          sbq[$];
  logic [AW-1:0] e_addr[int];
  bit            e_wr[int];
  logic [7:0]    e_dout[int];
  bit            e_busy[int];
  logic [31:0]   last_inst;
  logic [31:0]   last_load;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  // Reference model: applies the whole transfer at issue time and records
  // when each RAM byte access and the completion pulse must appear.
  task automatic push_txn(input bit is_if, input bit we, input int n,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int start);
    exp_t          e;
    logic [31:0]   d;
    logic [AW-1:0] ad;
    d = '0;
    for (int k = 0; k < n; k++) begin
      ad = AW'(a + 32'(k));
      e_addr[start+1+k] = ad;
      e_wr[start+1+k]   = we;
      e_dout[start+1+k] = wd[8*k +: 8];
      if (we) refm[ad] = wd[8*k +: 8];
      else    d[8*k +: 8] = refm[ad];
    end
    for (int j = 1; j <= (we ? n : n + 1); j++) e_busy[start+j] = 1'b1;
    e.is_if = is_if;
    e.we    = we;
    e.data  = d;
    e.cyc   = start + (we ? n + 1 : n + 2);
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (e_addr.exists(cyc)) begin
      chk("ram_addr", 32'(ram_addr_o), 32'(e_addr[cyc]));
      chk("ram_wr", 32'(ram_wr_o), 32'(e_wr[cyc]));
      if (e_wr[cyc]) chk("ram_dout", 32'(ram_dout_o), 32'(e_dout[cyc]));
      e_addr.delete(cyc);
      e_wr.delete(cyc);
      e_dout.delete(cyc);
    end else begin
      chk("ram_wr_quiet", 32'(ram_wr_o), 32'd0);
    end
    chk("busy", 32'(busy_o), 32'(e_busy.exists(cyc)));
    if (e_busy.exists(cyc)) e_busy.delete(cyc);
    if (if_done_o && mem_done_o) chk("done_overlap", 32'd1, 32'd0);
    if (if_done_o || mem_done_o) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("done_kind", 32'(if_done_o), 32'(e.is_if));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        if (e.is_if) begin
          chk("if_inst", if_inst_o, e.data);
          chk("mem_data_hold", mem_data_o, last_load);
          last_inst = e.data;
        end else if (!e.we) begin
          chk("mem_data", mem_data_o, e.data);
          chk("if_inst_hold", if_inst_o, last_inst);
          last_load = e.data;
        end else begin
          chk("mem_data_hold", mem_data_o, last_load);
          chk("if_inst_hold", if_inst_o, last_inst);
        end
      end
    end
  end

  task automatic wait_done(input bit want_if, input bit scr);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (want_if ? if_done_o : mem_done_o) begin
        ok = 1'b1;
        break;
      end
      if (scr) begin
        if (want_if) begin
          if_addr_i = $urandom;
        end else begin
          mem_addr_i  = $urandom;
          mem_wdata_i = $urandom;
          mem_width_i = 2'($urandom);
          mem_we_i    = 1'($urandom);
        end
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL done_timeout: got no %s done, required within 30 cycles",
               want_if ? "fetch" : "mem");
    end
  endtask

  // kind: 0 fetch, 1 load/store, 2 both at once. Called at an IDLE negedge.
  task automatic run_txn(input int kind, input bit we, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] fa, input bit scr);
    int start;
    start = cyc;
    if (kind != 0) begin
      mem_req_i   = 1'b1;
      mem_we_i    = we;
      mem_width_i = w;
      mem_addr_i  = a;
      mem_wdata_i = wd;
      push_txn(1'b0, we, nbytes(w), a, wd, start);
    end
    if (kind != 1) begin
      if_req_i  = 1'b1;
      if_addr_i = fa;
      if (kind == 0) push_txn(1'b1, 1'b0, 4, fa, '0, start);
    end
    if (kind != 0) begin
      wait_done(1'b0, scr);
      mem_req_i = 1'b0;
      if (kind == 2) push_txn(1'b1, 1'b0, 4, fa, '0, cyc + 1);
    end
    if (kind != 1) begin
      wait_done(1'b1, scr && kind == 0);
      if_req_i = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]  b;
    logic [7:0]  old2;
    logic [7:0]  old3;
    logic [31:0] wd;
    int          k;
    last_inst = '0;
    last_load = '0;
    for (int i = 0; i < MSZ; i++) begin
      b = 8'($urandom);
      ram[i] <= b;
      refm[i] = b;
    end
    ram[32'h100] <= 8'h13; refm[32'h100] = 8'h13;
    ram[32'h101] <= 8'h05; refm[32'h101] = 8'h05;
    ram[32'h102] <= 8'hA0; refm[32'h102] = 8'hA0;
    ram[32'h103] <= 8'h00; refm[32'h103] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_if_inst", if_inst_o, 32'd0);
    chk("rst_mem_data", mem_data_o, 32'd0);
    chk("rst_ram_addr", 32'(ram_addr_o), 32'd0);
    chk("rst_dones", 32'({if_done_o, mem_done_o}), 32'd0);
    rst = 1'b1;

    run_txn(0, 1'b0, 2'b10, '0, '0, 32'h100, 1'b0);
    chk("fetch_0x100", if_inst_o, 32'h00A00513);

    run_txn(1, 1'b1, 2'b00, 32'h20, 32'h123456AB, '0, 1'b0);
    chk("store_byte_ram", 32'(ram[32'h20]), 32'hAB);
    run_txn(1, 1'b0, 2'b10, 32'h20, '0, '0, 1'b0);
    chk("load_low_byte", 32'(mem_data_o[7:0]), 32'hAB);

    run_txn(2, 1'b0, 2'b01, 32'h40, '0, 32'h100, 1'b0);
    run_txn(1, 1'b0, 2'b10, 32'h1FFFE, '0, '0, 1'b0);

    wd   = 32'hCAFEF00D;
    old2 = refm[32'h302];
    old3 = refm[32'h303];
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_width_i = 2'b10;
    mem_addr_i  = 32'h300;
    mem_wdata_i = wd;
    push_txn(1'b0, 1'b1, 4, 32'h300, wd, cyc);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_req_i = 1'b0;
    #1;
    chk("abort_wr", 32'(ram_wr_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    void'(sbq.pop_back());
    e_addr.delete();
    e_wr.delete();
    e_dout.delete();
    e_busy.delete();
    refm[32'h302] = old2;
    refm[32'h303] = old3;
    last_inst = '0;
    last_load = '0;
    @(negedge clk);
    chk("abort_if_inst", if_inst_o, 32'd0);
    chk("abort_mem_data", mem_data_o, 32'd0);
    chk("abort_ram_addr", 32'(ram_addr_o), 32'd0);
    chk("abort_b0", 32'(ram[32'h300]), 32'(wd[7:0]));
    chk("abort_b1", 32'(ram[32'h301]), 32'(wd[15:8]));
    chk("abort_b2", 32'(ram[32'h302]), 32'(old2));
    chk("abort_b3", 32'(ram[32'h303]), 32'(old3));
    rst = 1'b1;
    run_txn(0, 1'b0, 2'b10, '0, '0, 32'h300, 1'b0);

    for (int t = 0; t < 200; t++) begin
      k = int'($urandom_range(0, 3));
      run_txn(k == 3 ? 2 : (k == 0 ? 0 : 1), 1'($urandom),
              2'($urandom), $urandom, $urandom, $urandom,
              1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
